// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module     : spi_pkg
// Description: Shared types and default widths for the SPI command decoder
//              slice. Exports the decoder state encoding and the default
//              byte and register-address widths.
// Revision   : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Default byte width; must match the SPI shift engine width.
  localparam int N_DEF      = 8;
  // Default register address width (register file depth = 2**ADDR_W_DEF).
  localparam int ADDR_W_DEF = 4;
  // Position of the read/write flag inside a command byte.
  localparam int CMD_RD_BIT = N_DEF - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    RLOAD  = 3'd3,
    RWAIT  = 3'd4,
    IGNORE = 3'd5
  } cmd_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_regfile.sv
`default_nettype none
// ============================================================================
// Module     : spi_regfile
// Description: 2**ADDR_W x N register file. One synchronous write port and
//              two independent combinational read ports. All entries are
//              cleared by the asynchronous reset.
// Ports      : clk_i, reset_i        - clock, async active-high reset
//              we_i, waddr_i, wdata_i - write port
//              raddr_a_i / rdata_a_o  - read port A (transmit path)
//              raddr_b_i / rdata_b_o  - read port B (host path)
// Revision   : 1.0 - initial release
// ============================================================================
module spi_regfile #(
  parameter int N      = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [N-1:0]      wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [N-1:0]      rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [N-1:0]      rdata_b_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module     : spi_cmd_decoder
// Description: Byte-level protocol stage behind the SPI shift engine. The
//              first byte of a frame is a command (R flag, reserved bits,
//              start address); following bytes are register writes or read
//              slots that reload the shift engine via tx_start/tx_write.
// Ports      : clk_i, reset_i          - clock, async active-high reset
//              frame_i                 - chip select active
//              rx_done_i, rx_data_i    - received byte strobe and data
//              tx_start_o, tx_write_o, tx_data_o - shift engine reload
//              wr_strobe_o, wr_addr_o  - registered write notification
//              host_addr_i, host_rdata_o - local combinational read
//              err_o, err_clr_i        - sticky malformed-command flag
// Revision   : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder
  import spi_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_i,
  input  logic              rx_done_i,
  input  logic [N-1:0]      rx_data_i,
  output logic              tx_start_o,
  output logic              tx_write_o,
  output logic [N-1:0]      tx_data_o,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  output logic [N-1:0]      host_rdata_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  cmd_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;
  logic              we;
  logic [N-1:0]      tx_rdata;
  logic              rsvd_bad;
  logic              is_read;

  // Bits between the R flag and the address field must be zero.
  assign rsvd_bad = |rx_data_i[N-2:ADDR_W];
  // R flag is the MSB of the command byte (CMD_RD_BIT at default width).
  assign is_read  = rx_data_i[N-1];

  spi_regfile #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .we_i      (we),
    .waddr_i   (ptr_q),
    .wdata_i   (rx_data_i),
    .raddr_a_i (ptr_q),
    .rdata_a_o (tx_rdata),
    .raddr_b_i (host_addr_i),
    .rdata_b_o (host_rdata_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    we          = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    // Clear first so that a new error detected below overrides it.
    err_d       = err_clr_i ? 1'b0 : err_q;

    // Frame drop outranks any byte arriving in the same cycle.
    if (state_q != IDLE && !frame_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_i) state_d = CMD;
        end
        CMD: begin
          if (rx_done_i) begin
            if (rsvd_bad) begin
              err_d   = 1'b1;
              state_d = IGNORE;
            end else begin
              ptr_d   = rx_data_i[ADDR_W-1:0];
              state_d = is_read ? RLOAD : WDATA;
            end
          end
        end
        WDATA: begin
          if (rx_done_i) begin
            we          = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
            ptr_d       = ptr_q + 1'b1;
          end
        end
        RLOAD: begin
          state_d = RWAIT;
        end
        RWAIT: begin
          // Byte shifted in during a read slot is a dummy; just advance.
          if (rx_done_i) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = RLOAD;
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Reload request is a Moore output of RLOAD; tx_data is zero elsewhere.
  assign tx_start_o  = (state_q == RLOAD);
  assign tx_write_o  = (state_q == RLOAD);
  assign tx_data_o   = (state_q == RLOAD) ? tx_rdata : '0;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Byte-level protocol stage directly downstream of the SPI shift engine.
- Consumes each received byte (`done` plus parallel data) and decodes the first byte of a frame as a command. Subsequent bytes are register writes, or read-data slots fed back to the shift engine through its start/write/pdatain inputs.
- Holds a small register file that is readable by local logic.

Parameters:
- N, 8: byte width; must equal the shift engine width.
- ADDR_W, 4: register address width; register file depth is 2**ADDR_W.

Ports:
- clk, input, 1: same clock that drives the shift engine.
- reset, input, 1: asynchronous, active-high reset.
- frame, input, 1: high while the chip select is active; low ends the transaction.
- rx_done, input, 1: one-cycle pulse indicating rx_data is valid.
- rx_data, input, N: received byte.
- tx_start, output, 1: one-cycle start pulse to the shift engine.
- tx_write, output, 1: load request to the shift engine; asserted together with tx_start.
- tx_data, output, N: byte to load for the next read slot.
- wr_strobe, output, 1: one-cycle pulse when a register is written.
- wr_addr, output, ADDR_W: address of the current write.
- host_addr, input, ADDR_W: local read address.
- host_rdata, output, N: combinational read of reg[host_addr].
- err, output, 1: sticky malformed-command flag.
- err_clr, input, 1: clears err.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All registers clear to 0.
  - tx_start, tx_write, wr_strobe, err = 0; tx_data = 0; wr_addr = 0; internal address pointer = 0.
- Command byte format: bit N-1 is R (1 = read, 0 = write). Bits N-2..ADDR_W must be 0. Bits ADDR_W-1..0 are the start address.
- States:
  - IDLE: when frame=1, go to CMD.
  - CMD: on rx_done, decode rx_data.
    - Reserved bits nonzero: set err, go to IGNORE.
    - W: ptr=addr, go to WDATA.
    - R: ptr=addr, go to RLOAD.
  - WDATA: on each rx_done:
    - reg[ptr] <= rx_data.
    - wr_strobe=1 and wr_addr=ptr in the following cycle (registered, latency 1).
    - ptr <= ptr+1, wrapping modulo 2**ADDR_W (0xF -> 0x0 at the default).
  - RLOAD: one cycle with tx_data=reg[ptr], tx_write=1, tx_start=1; then go to RWAIT.
  - RWAIT: on rx_done, ptr <= ptr+1 (wrapping), go to RLOAD. The received byte is discarded.
  - IGNORE: discard all bytes until frame falls.
- Frame termination: frame=0 in any non-IDLE state forces IDLE on the next edge. This has priority over rx_done in the same cycle: that byte is dropped, no write happens, and no wr_strobe is issued.
- Partial commands: frame dropping before the command byte produces no error and no side effects.
- Read timing: the first read byte is loaded the cycle after the command decode. The upstream engine must not be restarted while it is shifting; it is only restarted after rx_done, per the handshake above.
- Register file: written only in WDATA. tx_data samples the register value at the RLOAD cycle.
- Error flag: err is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, the error wins (err stays 1).
- Re-entry: back-to-back frames need at least one cycle of frame=0 between them. frame high straight out of reset goes IDLE -> CMD normally.
- Mid-operation reset: asynchronous reset clears everything immediately, including the register contents. Outputs are 0 while reset is held.

Decomposition:
- Package spi_pkg holds:
  - typedef enum {IDLE, CMD, WDATA, RLOAD, RWAIT, IGNORE} cmd_state_t.
  - Constants CMD_RD_BIT = N-1 and the default widths.
- One sub-module, spi_regfile: 2**ADDR_W x N registers with one synchronous write port and two combinational read ports (tx path and host path), cleared by reset.
- The FSM and pointer logic stay in spi_cmd_decoder.

Test Plan:
- Write burst:
  - Stimulus: frame=1; rx bytes 0x02, 0xAA, 0x55.
  - Expected: reg[2]=0xAA, reg[3]=0x55. wr_strobe pulses twice with wr_addr 2 then 3. host_addr=3 gives host_rdata=0x55. err=0.
- Read burst:
  - Stimulus: preload reg[5]=0x3C, reg[6]=0xC3; frame=1; rx 0x85, then dummy bytes.
  - Expected: tx_start/tx_write pulse with tx_data=0x3C, then after the next rx_done with 0xC3. No wr_strobe.
- Wrap-around:
  - Stimulus: write command 0x0F, data 0x11, 0x22.
  - Expected: reg[15]=0x11, reg[0]=0x22, wr_addr sequence F then 0.
- Malformed command:
  - Stimulus: rx 0x42 (reserved bit set), then 0x99.
  - Expected: err=1, no writes, state IGNORE.
  - Then frame=0 and err_clr=1: err returns to 0; the next frame with command 0x01 decodes normally.
- Frame drop collision:
  - Stimulus: in WDATA, frame falls in the same cycle as rx_done with 0x77.
  - Expected: no register change, no wr_strobe, state IDLE next cycle.
- Reset mid-burst:
  - Stimulus: assert reset during RWAIT.
  - Expected: outputs 0 immediately, registers 0, state IDLE. After release, a write command 0x00, 0x01 results in reg[0]=0x01.
